// File: rtl/act_fp_pkg.sv
// Shared constants and helpers for the act_fp activation stream.
// Extended float: {exn[1:0], sign, exp[WE-1:0], frac[WF-1:0]}.
package act_fp_pkg;

  localparam logic [1:0] EXN_ZERO = 2'b00;
  localparam logic [1:0] EXN_NORM = 2'b01;
  localparam logic [1:0] EXN_INF  = 2'b10;
  localparam logic [1:0] EXN_NAN  = 2'b11;

  localparam logic [1:0] MODE_ID    = 2'd0;
  localparam logic [1:0] MODE_RELU  = 2'd1;
  localparam logic [1:0] MODE_LEAKY = 2'd2;
  localparam logic [1:0] MODE_CLAMP = 2'd3;

  function automatic int fp_w(input int we, input int wf);
    return we + wf + 3;
  endfunction

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

endpackage

// File: rtl/act_fp_lane.sv
// Combinational per-element activation for one lane.
// Class flags come precomputed from the capture stage.
module act_fp_lane
  import act_fp_pkg::*;
#(
  parameter int WE = 8,
  parameter int WF = 23,
  parameter int LEAKY_SHIFT = 2,
  parameter logic [WE+WF+2:0] CLAMP_VAL = 34'h140c00000
) (
  input  logic [1:0]       mode,
  input  logic [WE+WF+2:0] x,
  input  logic             is_nan,
  input  logic             is_neg,
  output logic [WE+WF+2:0] y
);

  localparam int W = WE + WF + 3;
  localparam logic [WE-1:0] LS = WE'(LEAKY_SHIFT);

  logic [1:0]       exn;
  logic             sgn;
  logic [WE-1:0]    ex;
  logic [WF-1:0]    fr;
  logic [W-1:0]     relu_y;
  logic [W-1:0]     leaky_y;
  logic [W-1:0]     clamp_y;
  logic             over;

  assign exn = x[W-1 -: 2];
  assign sgn = x[WE+WF];
  assign ex  = x[WE+WF-1:WF];
  assign fr  = x[WF-1:0];

  // Compute every mode's result, then select by mode.
  always_comb begin
    relu_y = x;
    if (is_neg) begin
      if (exn == EXN_ZERO)
        relu_y = '0;
      else
        relu_y = {EXN_NORM, {(WE+WF+1){1'b0}}};
    end

    leaky_y = x;
    if (is_neg && exn == EXN_NORM) begin
      if (ex < LS)
        leaky_y = {EXN_ZERO, 1'b1, {(WE+WF){1'b0}}};
      else
        leaky_y = {exn, sgn, ex - LS, fr};
    end

    over = relu_y[WE+WF-1:0] > CLAMP_VAL[WE+WF-1:0];
    clamp_y = relu_y;
    if (relu_y[W-1 -: 2] == EXN_INF ||
        (relu_y[W-1 -: 2] == EXN_NORM && over))
      clamp_y = CLAMP_VAL;

    y = x;
    if (!is_nan) begin
      unique case (mode)
        MODE_ID:    y = x;
        MODE_RELU:  y = relu_y;
        MODE_LEAKY: y = leaky_y;
        MODE_CLAMP: y = clamp_y;
      endcase
    end
  end

endmodule

// File: rtl/act_fp_stream.sv
// Two-stage valid/ready activation stream, LANES elements per beat.
// Optional ACT_FP_STATS_EN adds negative/NaN lane counters.
module act_fp_stream
  import act_fp_pkg::*;
#(
  parameter int WE = 8,
  parameter int WF = 23,
  parameter int LANES = 4,
  parameter int LEAKY_SHIFT = 2,
  parameter logic [WE+WF+2:0] CLAMP_VAL = 34'h140c00000,
  localparam int W = fp_w(WE, WF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_mode,
  input  logic [LANES*W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_data
`ifdef ACT_FP_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [31:0]        stat_neg,
  output logic [31:0]        stat_nan
`endif
);

  logic               s1_valid;
  logic [1:0]         s1_mode;
  logic [LANES*W-1:0] s1_data;
  logic [LANES-1:0]   s1_nan;
  logic [LANES-1:0]   s1_neg;
  logic               s2_valid;
  logic [LANES*W-1:0] s2_data;
  logic               s1_ld;
  logic               s2_ld;
  logic               in_fire;
  logic [LANES-1:0]   in_nan;
  logic [LANES-1:0]   in_neg;
  logic [LANES*W-1:0] lane_vec;

  assign s2_ld    = !s2_valid || out_ready;
  assign s1_ld    = !s1_valid || s2_ld;
  assign in_ready = s1_ld;
  assign in_fire  = in_valid && in_ready;

  assign out_valid = s2_valid;
  assign out_data  = s2_data;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign in_nan[i] = in_data[i*W+W-1 -: 2] == EXN_NAN;
    assign in_neg[i] = in_data[i*W+W-3] && !in_nan[i];

    act_fp_lane #(
      .WE(WE),
      .WF(WF),
      .LEAKY_SHIFT(LEAKY_SHIFT),
      .CLAMP_VAL(CLAMP_VAL)
    ) u_lane (
      .mode(s1_mode),
      .x(s1_data[i*W +: W]),
      .is_nan(s1_nan[i]),
      .is_neg(s1_neg[i]),
      .y(lane_vec[i*W +: W])
    );
  end

  // Stage 1: capture the input beat with its mode and lane classes.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= MODE_ID;
      s1_data  <= '0;
      s1_nan   <= '0;
      s1_neg   <= '0;
    end else if (s1_ld) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode <= in_mode;
        s1_data <= in_data;
        s1_nan  <= in_nan;
        s1_neg  <= in_neg;
      end
    end
  end

  // Stage 2: register lane results; holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else if (s2_ld) begin
      s2_valid <= s1_valid;
      if (s1_valid)
        s2_data <= lane_vec;
    end
  end

`ifdef ACT_FP_STATS_EN
  logic [31:0] neg_cnt;
  logic [31:0] nan_cnt;

  // Count classified lanes of the beat being offered.
  always_comb begin
    neg_cnt = '0;
    nan_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      neg_cnt = neg_cnt + 32'(in_neg[i]);
      nan_cnt = nan_cnt + 32'(in_nan[i]);
    end
  end

  // Saturating counters; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_neg <= '0;
      stat_nan <= '0;
    end else if (in_fire) begin
      stat_neg <= sat_add(stat_neg, neg_cnt);
      stat_nan <= sat_add(stat_nan, nan_cnt);
    end
  end
`else
  logic unused_fire;
  assign unused_fire = in_fire;
`endif

endmodule

// File: tb/tb_act_fp_stream.sv
// Scoreboard bench for act_fp_stream: directed vectors,
// backpressure, mid-stream reset and optional stats.
module tb_act_fp_stream;
  import act_fp_pkg::*;

  localparam int W = 34;
  localparam int L = 4;
  localparam int BW = L * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_mode = MODE_ID;
  logic [BW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [BW-1:0] out_data;
`ifdef ACT_FP_STATS_EN
  logic          stat_clr = 1'b0;
  logic [31:0]   stat_neg;
  logic [31:0]   stat_nan;
`endif

  always #5 clk = ~clk;

  act_fp_stream dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_mode(in_mode),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
`ifdef ACT_FP_STATS_EN
    ,
    .stat_clr(stat_clr),
    .stat_neg(stat_neg),
    .stat_nan(stat_nan)
`endif
  );

  typedef struct {
    logic [BW-1:0] d;
    int            cyc;
    bit            lat;
  } exp_t;

  exp_t q[$];
  exp_t me;
  exp_t pe;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;
  bit   rnd_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [BW-1:0] act,
                       input logic [BW-1:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, req);
  endtask

  function automatic logic [BW-1:0] pack(
    input logic [W-1:0] a, input logic [W-1:0] b,
    input logic [W-1:0] c, input logic [W-1:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [BW-1:0] bp(input int i);
    logic [BW-1:0] v;
    for (int j = 0; j < L; j++)
      v[j*W +: W] = {2'b01, 32'(i * 16 + j + 1)};
    return v;
  endfunction

  // Monitor: pop on accepted outputs, peek while stalled.
  always @(negedge clk) begin
    if (mon_en && !rst && out_valid) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_beat: got %h want none", out_data);
      end else if (out_ready) begin
        me = q.pop_front();
        check("beat", out_data, me.d);
        if (me.lat) check("latency", BW'(cyc - me.cyc), BW'(2));
      end else begin
        check("stall_hold", out_data, q[0].d);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_en) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [1:0] m, input logic [BW-1:0] d,
                      input logic [BW-1:0] e, input bit push,
                      input bit lat);
    in_mode = m;
    in_data = d;
    in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        if (push) begin
          pe.d = e;
          pe.cyc = cyc;
          pe.lat = lat;
          q.push_back(pe);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    n_chk++;
    $display("FAIL send_timeout: in_ready low for 100 cycles");
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    for (int k = 0; k < 300; k++) begin
      if (q.size() == 0) return;
      @(posedge clk);
      #1;
    end
    n_chk++;
    $display("FAIL drain_timeout: %0d beats left want 0", q.size());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", BW'(out_valid), BW'(0));
    check("rst_out_data", out_data, '0);
    check("rst_in_ready", BW'(in_ready), BW'(1));
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    send(MODE_RELU,
         pack(34'h1bf800000, 34'h13f800000, 34'h300000001, 34'h080000000),
         pack(34'h100000000, 34'h13f800000, 34'h300000001, 34'h000000000),
         1'b1, 1'b1);
    send(MODE_LEAKY,
         pack(34'h1bf800000, 34'h180800000, 34'h280000000, 34'h13f800000),
         pack(34'h1be800000, 34'h080000000, 34'h280000000, 34'h13f800000),
         1'b1, 1'b0);
    send(MODE_LEAKY,
         pack(34'h181000000, 34'h300000001, 34'h080000000, 34'h000000000),
         pack(34'h180000000, 34'h300000001, 34'h080000000, 34'h000000000),
         1'b1, 1'b0);
    send(MODE_CLAMP,
         pack(34'h141000000, 34'h200000000, 34'h13f800000, 34'h140c00000),
         pack(34'h140c00000, 34'h140c00000, 34'h13f800000, 34'h140c00000),
         1'b1, 1'b0);
    send(MODE_CLAMP,
         pack(34'h1bf800000, 34'h300000001, 34'h000000000, 34'h140c00001),
         pack(34'h100000000, 34'h300000001, 34'h000000000, 34'h140c00000),
         1'b1, 1'b0);
    send(MODE_ID,
         pack(34'h1bf800000, 34'h280000000, 34'h080000000, 34'h300400000),
         pack(34'h1bf800000, 34'h280000000, 34'h080000000, 34'h300400000),
         1'b1, 1'b0);
    wait_empty();

    out_ready = 1'b0;
    acc = 0;
    in_mode = MODE_ID;
    in_data = bp(0);
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (in_ready) begin
        pe.d = bp(acc);
        pe.cyc = cyc;
        pe.lat = 1'b0;
        q.push_back(pe);
        acc++;
      end
      @(posedge clk);
      #1;
      in_data = bp(acc);
    end
    @(negedge clk);
    check("bp_in_ready", BW'(in_ready), BW'(0));
    check("bp_accepted", BW'(acc), BW'(2));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rnd_en = 1'b1;
    for (int i = acc; i < 10; i++)
      send(MODE_ID, bp(i), bp(i), 1'b1, 1'b0);
    rnd_en = 1'b0;
    out_ready = 1'b1;
    wait_empty();

    out_ready = 1'b0;
    mon_en = 1'b0;
    send(MODE_ID, bp(20), bp(20), 1'b0, 1'b0);
    send(MODE_ID, bp(21), bp(21), 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", BW'(out_valid), BW'(0));
    check("midrst_in_ready", BW'(in_ready), BW'(1));
    mon_en = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

`ifdef ACT_FP_STATS_EN
    for (int i = 0; i < 3; i++)
      send(MODE_RELU,
           pack(34'h1bf800000, 34'h180800000, 34'h300000001, 34'h13f800000),
           pack(34'h100000000, 34'h100000000, 34'h300000001, 34'h13f800000),
           1'b1, 1'b0);
    check("stat_neg", BW'(stat_neg), BW'(6));
    check("stat_nan", BW'(stat_nan), BW'(3));
    stat_clr = 1'b1;
    send(MODE_RELU,
         pack(34'h1bf800000, 34'h180800000, 34'h300000001, 34'h13f800000),
         pack(34'h100000000, 34'h100000000, 34'h300000001, 34'h13f800000),
         1'b1, 1'b0);
    stat_clr = 1'b0;
    check("stat_neg_clr", BW'(stat_neg), BW'(0));
    check("stat_nan_clr", BW'(stat_nan), BW'(0));
    wait_empty();
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
